median_seq: RTL and testbench
=============================

MEDIAN_SEQ -- requirements
Module: median_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8: pixel width in bits.
REQ-002 SHALL have port CLK  input  1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port nRST  input  1: reset, asynchronous and active-low.
REQ-004 SHALL have port DI  input  WIDTH: incoming pixel.
REQ-005 SHALL have port DSI  input  1: DI valid; a window is 9 consecutive accepted pixels.
REQ-006 SHALL have port READY  output  1: pixel accepted on any edge where DSI=1 and READY=1.
REQ-007 SHALL have port MED_DI  output  WIDTH: pixel to the downstream sorting stage.
REQ-008 SHALL have port MED_DSI  output  1: load strobe to the sorting stage.
REQ-009 SHALL have port MED_BYP  output  1: bypass control to the sorting stage.
REQ-010 SHALL have port MED_DO  input  WIDTH: sorting-stage output.
REQ-011 SHALL have port DO  output  WIDTH: registered median.
REQ-012 SHALL have port DSO  output  1: one-cycle pulse, DO valid.
REQ-013 SHALL have port ERR  output  1: sticky protocol-error flag (see Configuration).

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, SORT, DONE.
REQ-015 SHALL hold READY=1 in IDLE and LOAD only, and READY=0 in SORT and DONE.
REQ-016 SHALL drive MED_DI=DI combinationally in all states.
REQ-017 SHALL drive MED_DSI=DSI&READY combinationally, and MED_DSI=0 in SORT and DONE.
REQ-018 SHALL drive MED_BYP=1 in IDLE, LOAD and DONE.
REQ-019 IDLE: on DSI=1, SHALL accept pixel 1 and move to LOAD with load count=1.
REQ-020 LOAD: on each DSI=1 edge, SHALL increment the load count, and on the edge accepting pixel 9 SHALL move to SORT.
REQ-021 LOAD: if DSI=0 on any edge, SHALL abort the window and go to IDLE; the sorting stage contents are discarded.
REQ-022 SORT SHALL last exactly 40 cycles, organized as pass p=0..4 with in-pass cycle index c.
REQ-023 Passes p=0..3 SHALL run 9 cycles each: MED_BYP=0 for c=0..7-p, then MED_BYP=1 for the remaining p+1 cycles.
REQ-024 Pass 4 SHALL run 4 cycles with MED_BYP=0, after which the FSM moves to DONE.
REQ-025 DONE SHALL last exactly 1 cycle; on the edge leaving DONE, SHALL load DO<=MED_DO and set DSO=1, and the FSM returns to IDLE.
REQ-026 DSO SHALL be high for exactly one cycle per completed window; DO SHALL hold its value until the next capture.
REQ-027 Latency: if pixel 1 is accepted at edge E, DSO and the new DO SHALL be visible after edge E+49.
REQ-028 Throughput: SHALL accept the next window's pixel 1 at edge E+50 at the earliest, and back-to-back windows SHALL lose no pixel.
REQ-029 SHALL ignore DSI while READY=0; no pixel is consumed.
REQ-030 Counters SHALL never wrap: the pass counter is 3 bits, the cycle counter 4 bits, and the load counter 4 bits, each cleared on every state entry.

Reset
REQ-031 On nRST=0 the block SHALL immediately enter IDLE, clear all counters, and set DO=0, DSO=0 and ERR=0.
REQ-032 Reset asserted mid-LOAD or mid-SORT SHALL abandon the window with no DSO; the first window after reset SHALL start cleanly.

Configuration
REQ-033 Macro MEDIAN_SEQ_ERR_EN defined: ERR SHALL be set on the edge of a LOAD abort (REQ-021) or of DSI=1 while in SORT/DONE, and SHALL stay set until nRST.
REQ-034 Macro MEDIAN_SEQ_ERR_EN undefined: ERR SHALL be tied to 0 and no error logic SHALL be synthesized; all other behaviour SHALL be identical.

Verification
REQ-035 Bench SHALL apply pixels 9,8,7,6,5,4,3,2,1 with DSI=1 for 9 consecutive cycles (sorting stage attached) -> DO=5, DSO pulse exactly 49 edges after pixel 1.
REQ-036 Bench SHALL apply 0,255,0,255,0,255,0,255,0 -> DO=0; then all nine pixels 0xFF -> DO=0xFF.
REQ-037 Bench SHALL apply DSI low after pixel 4 -> return to IDLE with no DSO; ERR=1 only with MEDIAN_SEQ_ERR_EN defined; a following clean window 1..9 -> DO=5.
REQ-038 Bench SHALL hold DSI high continuously with two windows, 1..9 then 19..11 -> DSOs 50 cycles apart, DO=5 then DO=15, no pixels consumed during SORT.
REQ-039 Bench SHALL pulse nRST low during SORT cycle 20 -> DO=0 and DSO=0 immediately, no DSO; next window 2,4,6,8,10,12,14,16,18 -> DO=10.
REQ-040 Bench SHALL check the MED_BYP sequence per window against REQ-023/REQ-024: 0-counts 8,7,6,5,4 and 1-counts 1,2,3,4.

Source files
------------

// File: rtl/median_seq.sv
// Sequencer for a serial 3x3 median filter: loads 9 pixels into an external bubble-sort stage,
// steps it through 5 passes, and captures the median. MEDIAN_SEQ_ERR_EN enables the sticky ERR flag.
module median_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [WIDTH-1:0] DI,
    input  logic             DSI,
    output logic             READY,
    output logic [WIDTH-1:0] MED_DI,
    output logic             MED_DSI,
    output logic             MED_BYP,
    input  logic [WIDTH-1:0] MED_DO,
    output logic [WIDTH-1:0] DO,
    output logic             DSO,
    output logic             ERR
);

    typedef enum logic [1:0] {StIdle, StLoad, StSort, StDone} state_e;

    state_e           state_q;
    logic [3:0]       load_cnt_q;
    logic [3:0]       cyc_q;
    logic [2:0]       pass_q;
    logic             ready_q;
    logic             byp_q;
    logic             dso_q;
    logic [WIDTH-1:0] do_q;
    logic [3:0]       pass_cyc_sum;

    // Next cycle is a bypass cycle once c+1 > 7-p, i.e. c+p >= 7.
    assign pass_cyc_sum = cyc_q + {1'b0, pass_q};

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= StIdle;
            load_cnt_q <= '0;
            cyc_q      <= '0;
            pass_q     <= '0;
            ready_q    <= 1'b1;
            byp_q      <= 1'b1;
            dso_q      <= 1'b0;
            do_q       <= '0;
        end else begin
            dso_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (DSI) begin
                        state_q    <= StLoad;
                        load_cnt_q <= 4'd1;
                    end
                end
                StLoad: begin
                    if (!DSI) begin
                        state_q    <= StIdle;
                        load_cnt_q <= '0;
                    end else if (load_cnt_q == 4'd8) begin
                        state_q    <= StSort;
                        load_cnt_q <= '0;
                        cyc_q      <= '0;
                        pass_q     <= '0;
                        ready_q    <= 1'b0;
                        byp_q      <= 1'b0;
                    end else begin
                        load_cnt_q <= load_cnt_q + 4'd1;
                    end
                end
                StSort: begin
                    if (pass_q == 3'd4) begin
                        if (cyc_q == 4'd3) begin
                            state_q <= StDone;
                            cyc_q   <= '0;
                            pass_q  <= '0;
                            byp_q   <= 1'b1;
                        end else begin
                            cyc_q <= cyc_q + 4'd1;
                        end
                    end else if (cyc_q == 4'd8) begin
                        pass_q <= pass_q + 3'd1;
                        cyc_q  <= '0;
                        byp_q  <= 1'b0;
                    end else begin
                        cyc_q <= cyc_q + 4'd1;
                        byp_q <= (pass_cyc_sum >= 4'd7);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    ready_q <= 1'b1;
                    do_q    <= MED_DO;
                    dso_q   <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign READY   = ready_q;
    assign MED_DI  = DI;
    assign MED_DSI = DSI & ready_q;
    assign MED_BYP = byp_q;
    assign DO      = do_q;
    assign DSO     = dso_q;

`ifdef MEDIAN_SEQ_ERR_EN
    logic err_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            err_q <= 1'b0;
        end else if ((state_q == StLoad && !DSI) ||
                     ((state_q == StSort || state_q == StDone) && DSI)) begin
            err_q <= 1'b1;
        end
    end

    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_median_seq.sv
// Bench for median_seq with an attached serial bubble-sort stage; checks medians, latency,
// bypass sequencing, abort, streaming and mid-sort reset against a sort-based reference.
module tb_median_seq;

    localparam int unsigned WIDTH = 8;
`ifdef MEDIAN_SEQ_ERR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    typedef logic [7:0] pix_t [9];
    typedef struct {
        pix_t       px;
        logic [7:0] med;
    } vec_t;
    typedef struct {
        int         e;
        logic [7:0] d;
    } dso_t;

    logic             CLK = 1'b0;
    logic             nRST;
    logic [WIDTH-1:0] DI;
    logic             DSI;
    logic             READY;
    logic [WIDTH-1:0] MED_DI;
    logic             MED_DSI;
    logic             MED_BYP;
    logic [WIDTH-1:0] MED_DO;
    logic [WIDTH-1:0] DO;
    logic             DSO;
    logic             ERR;

    int   n_chk  = 0;
    int   n_fail = 0;
    int   edge_cnt = 0;
    int   acc_cnt  = 0;
    dso_t dso_q [$];
    logic exp_byp [40];
    vec_t vecs [6];

    median_seq #(.WIDTH(WIDTH)) dut (
        .CLK    (CLK),
        .nRST   (nRST),
        .DI     (DI),
        .DSI    (DSI),
        .READY  (READY),
        .MED_DI (MED_DI),
        .MED_DSI(MED_DSI),
        .MED_BYP(MED_BYP),
        .MED_DO (MED_DO),
        .DO     (DO),
        .DSO    (DSO),
        .ERR    (ERR)
    );

    always #5 CLK = ~CLK;

    // Sorting stage: load shifts in at the tail, bypass rotates, otherwise the head keeps the
    // larger of the first two entries and the smaller is pushed to the tail.
    logic [7:0] srt [9];
    always @(posedge CLK) begin
        if (MED_DSI) begin
            for (int i = 0; i < 8; i++) srt[i] <= srt[i+1];
            srt[8] <= MED_DI;
        end else if (MED_BYP) begin
            for (int i = 0; i < 8; i++) srt[i] <= srt[i+1];
            srt[8] <= srt[0];
        end else begin
            srt[0] <= (srt[0] > srt[1]) ? srt[0] : srt[1];
            for (int i = 1; i < 8; i++) srt[i] <= srt[i+1];
            srt[8] <= (srt[0] > srt[1]) ? srt[1] : srt[0];
        end
    end
    assign MED_DO = srt[0];

    always @(posedge CLK) begin
        dso_t rec;
        edge_cnt++;
        if (READY && DSI) acc_cnt++;
        #1;
        if (DSO) begin
            rec.e = edge_cnt;
            rec.d = DO;
            dso_q.push_back(rec);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_median(input pix_t px);
        logic [7:0] q [$];
        for (int i = 0; i < 9; i++) q.push_back(px[i]);
        q.sort();
        return q[4];
    endfunction

    // Called at a negedge; returns at the negedge after the edge that accepted v.
    task automatic send_px(input logic [7:0] v, output int e);
        int   n = 0;
        logic r;
        DI  = v;
        DSI = 1'b1;
        e   = -1;
        forever begin
            r = READY;
            @(negedge CLK);
            if (r) begin
                e = edge_cnt;
                break;
            end
            n++;
            if (n > 200) begin
                check("accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
    endtask

    task automatic wait_dso(output int e, output logic [7:0] d);
        int   n = 0;
        dso_t rec;
        while (dso_q.size() == 0 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (dso_q.size() == 0) begin
            check("dso_timeout", 32'd0, 32'd1);
            e = -1;
            d = 8'h00;
        end else begin
            rec = dso_q.pop_front();
            e   = rec.e;
            d   = rec.d;
        end
    endtask

    task automatic run_window(input pix_t px, input logic [7:0] exp_med);
        int         e0, e, bad;
        logic [7:0] m;
        for (int i = 0; i < 9; i++) begin
            send_px(px[i], e);
            if (i == 0) e0 = e;
        end
        DSI = 1'b0;
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            if (MED_BYP !== exp_byp[k] || READY !== 1'b0) bad++;
            @(negedge CLK);
        end
        check("byp_seq_errors", bad, 0);
        check("done_byp", MED_BYP, 1'b1);
        check("done_ready", READY, 1'b0);
        wait_dso(e, m);
        check("latency", e - e0, 49);
        check("median_table", m, exp_med);
        check("median_model", m, ref_median(px));
        @(negedge CLK);
        check("dso_single", DSO, 1'b0);
        check("do_hold", DO, m);
    endtask

    initial begin
        int         e, e1, e2, a0;
        logic [7:0] d1, d2;
        pix_t       px;

        begin
            int idx = 0;
            for (int p = 0; p < 4; p++)
                for (int c = 0; c < 9; c++) begin
                    exp_byp[idx] = (c > 7 - p);
                    idx++;
                end
            for (int c = 0; c < 4; c++) begin
                exp_byp[idx] = 1'b0;
                idx++;
            end
        end

        vecs[0].px = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        vecs[0].med = 8'd5;
        vecs[1].px = '{8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0};
        vecs[1].med = 8'd0;
        vecs[2].px = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        vecs[2].med = 8'hFF;
        vecs[3].px = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
        vecs[3].med = 8'd5;
        vecs[4].px = '{8'd19, 8'd18, 8'd17, 8'd16, 8'd15, 8'd14, 8'd13, 8'd12, 8'd11};
        vecs[4].med = 8'd15;
        vecs[5].px = '{8'd2, 8'd4, 8'd6, 8'd8, 8'd10, 8'd12, 8'd14, 8'd16, 8'd18};
        vecs[5].med = 8'd10;

        nRST = 1'b0;
        DSI  = 1'b0;
        DI   = 8'h00;
        repeat (2) @(negedge CLK);
        check("rst_ready", READY, 1'b1);
        check("rst_dso", DSO, 1'b0);
        check("rst_do", DO, 8'h00);
        check("rst_err", ERR, 1'b0);
        check("rst_byp", MED_BYP, 1'b1);
        check("rst_med_dsi", MED_DSI, 1'b0);
        nRST = 1'b1;
        @(negedge CLK);

        for (int v = 0; v < 3; v++) begin
            run_window(vecs[v].px, vecs[v].med);
            @(negedge CLK);
        end

        // Abort after pixel 4, then a clean window
        for (int i = 0; i < 4; i++) send_px(8'(i + 1), e);
        DSI = 1'b0;
        @(negedge CLK);
        check("abort_ready", READY, 1'b1);
        check("abort_byp", MED_BYP, 1'b1);
        check("abort_err", ERR, EXP_ERR);
        repeat (60) @(negedge CLK);
        check("abort_no_dso", dso_q.size(), 0);
        run_window(vecs[3].px, vecs[3].med);

        // Back-to-back windows with DSI held high throughout
        a0 = acc_cnt;
        for (int i = 0; i < 9; i++) begin
            send_px(vecs[3].px[i], e);
            if (i == 0) e1 = e;
        end
        for (int i = 0; i < 9; i++) begin
            send_px(vecs[4].px[i], e);
            if (i == 0) e2 = e;
        end
        DSI = 1'b0;
        check("stream_next_pixel1", e2 - e1, 50);
        wait_dso(e, d1);
        check("stream_dso1_lat", e - e1, 49);
        check("stream_do1", d1, 8'd5);
        e1 = e;
        wait_dso(e, d2);
        check("stream_dso_gap", e - e1, 50);
        check("stream_do2", d2, ref_median(vecs[4].px));
        check("stream_accepts", acc_cnt - a0, 18);
        @(negedge CLK);

        // Reset during SORT cycle 20
        for (int i = 0; i < 9; i++) send_px(8'(40 + i * 3), e);
        DSI = 1'b0;
        repeat (20) @(negedge CLK);
        DI  = 8'h5A;
        DSI = 1'b1;
        #1;
        check("med_di_comb", MED_DI, 8'h5A);
        check("sort_med_dsi", MED_DSI, 1'b0);
        DSI  = 1'b0;
        nRST = 1'b0;
        #1;
        check("midrst_do", DO, 8'h00);
        check("midrst_dso", DSO, 1'b0);
        check("midrst_ready", READY, 1'b1);
        check("midrst_err", ERR, 1'b0);
        #2;
        nRST = 1'b1;
        repeat (60) @(negedge CLK);
        check("midrst_no_dso", dso_q.size(), 0);
        run_window(vecs[5].px, vecs[5].med);

        // Random windows with random idle gaps
        for (int w = 0; w < 6; w++) begin
            repeat ($urandom_range(0, 3)) @(negedge CLK);
            for (int i = 0; i < 9; i++) px[i] = 8'($urandom_range(0, 255));
            run_window(px, ref_median(px));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
